// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Scoreboard-based forwarding and load-use hazard unit. It keeps a DEPTH-entry
// shift register that describes every in-flight instruction from EX (entry 0) to
// WB (entry DEPTH-1). For each source operand of the instruction in decode it
// finds the youngest in-flight producer. From that producer it works out either
// a forwarding select, which is registered into EX alongside the instruction, or
// a load-use stall.
//
// Ports
//   i_Clk          clock, all state changes on the rising edge
//   i_Rst          synchronous active-high reset
//   i_IssueValid   decode instruction is valid
//   i_IssueWe      decode instruction writes the register file
//   i_IssueDst     its destination register
//   i_IssueKind    result source: 10 ALU, 11 LDI, 01 LOAD, 00 none
//   i_SrcAddr      packed source addresses, source j at [j*REG_ADDR_W +: REG_ADDR_W]
//   i_SrcUsed      source j is actually read
//   i_Flush        squash the decode instruction and the one in EX
//   i_StallCntClr  clear the stall counter (wins over increment)
//   o_FwdSel       registered per-source select: 0 = RF, k = forward from stage k
//   o_Stall        combinational decode hold / bubble request
//   o_StallCnt     saturating stall-cycle count
module hazard_forward_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_SRC    = 2,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 2,
   parameter int CNT_W      = 16,
   parameter int SEL_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst,
   input  logic                          i_IssueValid,
   input  logic                          i_IssueWe,
   input  logic [REG_ADDR_W-1:0]         i_IssueDst,
   input  logic [1:0]                    i_IssueKind,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] i_SrcAddr,
   input  logic [NUM_SRC-1:0]            i_SrcUsed,
   input  logic                          i_Flush,
   input  logic                          i_StallCntClr,
   output logic [NUM_SRC*SEL_W-1:0]      o_FwdSel,
   output logic                          o_Stall,
   output logic [CNT_W-1:0]              o_StallCnt
);

   localparam logic [1:0] KIND_NONE = 2'b00;
   localparam logic [1:0] KIND_LOAD = 2'b01;

   logic [DEPTH-1:0]      ent_valid;
   logic [REG_ADDR_W-1:0] ent_dst  [DEPTH];
   logic [1:0]            ent_kind [DEPTH];

   logic [NUM_SRC-1:0]       hit;
   logic [NUM_SRC-1:0]       src_hazard;
   logic [NUM_SRC*SEL_W-1:0] sel_next;
   logic                     accept;
   logic                     issue_write;

   // Searching from k=0 upward and latching the first hit per source makes the
   // youngest producer win. A producer about to leave WB writes the RF this
   // cycle, and the RF is write-before-read, so that producer selects the RF.
   always_comb begin
      hit        = '0;
      src_hazard = '0;
      sel_next   = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (!hit[j] && i_SrcUsed[j] && ent_valid[k] && (ent_kind[k] != KIND_NONE) &&
                (ent_dst[k] == i_SrcAddr[j*REG_ADDR_W +: REG_ADDR_W])) begin
               hit[j] = 1'b1;
               if (k + 1 == DEPTH) begin
                  sel_next[j*SEL_W +: SEL_W] = '0;
               end else if ((ent_kind[k] == KIND_LOAD) && (k + 1 < LOAD_READY)) begin
                  src_hazard[j] = 1'b1;
               end else begin
                  sel_next[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
               end
            end
         end
      end
   end

   assign o_Stall     = i_IssueValid && !i_Flush && (|src_hazard);
   assign accept      = i_IssueValid && !o_Stall && !i_Flush;
   assign issue_write = accept && i_IssueWe;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         ent_valid  <= '0;
         o_FwdSel   <= '0;
         o_StallCnt <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            ent_dst[k]  <= '0;
            ent_kind[k] <= KIND_NONE;
         end
      end else begin
         ent_valid[0] <= issue_write;
         ent_dst[0]   <= i_IssueDst;
         ent_kind[0]  <= i_IssueKind;
         // Older stages always advance. On a flush the EX instruction dies as
         // it moves into MEM.
         for (int k = 1; k < DEPTH; k++) begin
            ent_valid[k] <= ent_valid[k-1] && !((k == 1) && i_Flush);
            ent_dst[k]   <= ent_dst[k-1];
            ent_kind[k]  <= ent_kind[k-1];
         end

         o_FwdSel <= accept ? sel_next : '0;

         if (i_StallCntClr) begin
            o_StallCnt <= '0;
         end else if (o_Stall && (o_StallCnt != {CNT_W{1'b1}})) begin
            o_StallCnt <= o_StallCnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed-vector bench for hazard_forward_unit (CNT_W=4 build so that
// saturation is reachable; other parameters at their defaults).
module tb_hazard_forward_unit;

   localparam logic [1:0] K_NONE = 2'b00;
   localparam logic [1:0] K_LOAD = 2'b01;
   localparam logic [1:0] K_ALU  = 2'b10;
   localparam logic [1:0] K_LDI  = 2'b11;

   logic        clk_sys;
   logic        rst;
   logic        issue_valid;
   logic        issue_we;
   logic [4:0]  issue_dst;
   logic [1:0]  issue_kind;
   logic [9:0]  src_addr;
   logic [1:0]  src_used;
   logic        flush;
   logic        cnt_clr;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic [3:0]  stall_cnt;

   int total = 0;
   int bad   = 0;

   hazard_forward_unit #(
      .REG_ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(2), .CNT_W(4)
   ) u_dut (
      .i_Clk        (clk_sys),
      .i_Rst        (rst),
      .i_IssueValid (issue_valid),
      .i_IssueWe    (issue_we),
      .i_IssueDst   (issue_dst),
      .i_IssueKind  (issue_kind),
      .i_SrcAddr    (src_addr),
      .i_SrcUsed    (src_used),
      .i_Flush      (flush),
      .i_StallCntClr(cnt_clr),
      .o_FwdSel     (fwd_sel),
      .o_Stall      (stall),
      .o_StallCnt   (stall_cnt)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic set_in(input logic v, input logic we, input logic [4:0] dst,
                         input logic [1:0] kind, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] used,
                         input logic fl);
      issue_valid = v;
      issue_we    = we;
      issue_dst   = dst;
      issue_kind  = kind;
      src_addr    = {s1, s0};
      src_used    = used;
      flush       = fl;
      #1;
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 1'b0, 5'd0, K_NONE, 5'd0, 5'd0, 2'b00, 1'b0);
      repeat (n) tick();
   endtask

   initial begin
      rst     = 1'b1;
      cnt_clr = 1'b0;
      set_in(1'b0, 1'b0, 5'd0, K_NONE, 5'd0, 5'd0, 2'b00, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      #1;
      chk("rst_stall", int'(stall), 0);
      chk("rst_sel",   int'(fwd_sel), 0);
      chk("rst_cnt",   int'(stall_cnt), 0);

      // ALU chaining: 0, 1 and 2 instructions between producer and consumer
      idle(3);
      set_in(1, 1, 5'd3, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd10, K_ALU, 5'd3, 5'd0, 2'b01, 0);
      chk("alu0_stall", int'(stall), 0);
      tick();
      chk("alu0_sel", int'(fwd_sel), 1);

      idle(3);
      set_in(1, 1, 5'd3, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd11, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd10, K_ALU, 5'd3, 5'd0, 2'b01, 0); tick();
      chk("alu1_sel", int'(fwd_sel), 2);

      idle(3);
      set_in(1, 1, 5'd3, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd11, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd12, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd10, K_ALU, 5'd3, 5'd0, 2'b01, 0); tick();
      chk("alu2_sel", int'(fwd_sel), 0);

      // Load-use directly after the load: one stall, then WB forward on src1
      idle(3);
      set_in(1, 1, 5'd5, K_LOAD, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd12, K_ALU, 5'd0, 5'd5, 2'b10, 0);
      chk("lu_stall1", int'(stall), 1);
      tick();
      chk("lu_stall_sel", int'(fwd_sel), 0);
      chk("lu_stall2", int'(stall), 0);
      chk("lu_cnt", int'(stall_cnt), 1);
      tick();
      chk("lu_sel", int'(fwd_sel), 8);

      // Load-use with one instruction between: no stall, select 2
      idle(3);
      set_in(1, 1, 5'd5, K_LOAD, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd13, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd14, K_ALU, 5'd5, 5'd0, 2'b01, 0);
      chk("lu1_stall", int'(stall), 0);
      tick();
      chk("lu1_sel", int'(fwd_sel), 2);

      // Youngest wins, both sources on the same producer
      idle(3);
      set_in(1, 1, 5'd4, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd4, K_LDI, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd15, K_ALU, 5'd4, 5'd4, 2'b11, 0);
      chk("yw_stall", int'(stall), 0);
      tick();
      chk("yw_sel", int'(fwd_sel), 5);

      // Flush in decode: the load never enters the pipeline
      idle(3);
      set_in(1, 1, 5'd7, K_LOAD, 5'd0, 5'd0, 2'b00, 1);
      chk("fl_dec_stall", int'(stall), 0);
      tick();
      set_in(1, 1, 5'd16, K_ALU, 5'd7, 5'd0, 2'b01, 0);
      chk("fl_dec_cons_stall", int'(stall), 0);
      tick();
      chk("fl_dec_sel", int'(fwd_sel), 0);

      // Flush during a would-be stall: flush wins, EX load squashed
      idle(3);
      set_in(1, 1, 5'd7, K_LOAD, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd16, K_ALU, 5'd7, 5'd0, 2'b01, 1);
      chk("fl_st_stall", int'(stall), 0);
      tick();
      chk("fl_st_cnt", int'(stall_cnt), 1);
      set_in(1, 1, 5'd16, K_ALU, 5'd7, 5'd0, 2'b01, 0);
      chk("fl_sq_stall", int'(stall), 0);
      tick();
      chk("fl_sq_sel", int'(fwd_sel), 0);

      // Unused source and non-writer kind
      idle(3);
      set_in(1, 1, 5'd8, K_ALU, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd17, K_ALU, 5'd8, 5'd0, 2'b00, 0); tick();
      chk("unused_sel", int'(fwd_sel), 0);
      idle(3);
      set_in(1, 1, 5'd9, K_NONE, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd17, K_ALU, 5'd9, 5'd0, 2'b01, 0); tick();
      chk("nowr_sel", int'(fwd_sel), 0);
      idle(3);
      set_in(1, 1, 5'd6, K_LOAD, 5'd0, 5'd0, 2'b00, 0); tick();
      set_in(1, 1, 5'd17, K_ALU, 5'd0, 5'd6, 2'b01, 0);
      chk("unused_ld_stall", int'(stall), 0);
      tick();
      chk("pre_clr_cnt", int'(stall_cnt), 1);

      // Counter: clear, then 19 stalls from a self-dependent load chain
      idle(2);
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("clr_cnt", int'(stall_cnt), 0);
      set_in(1, 1, 5'd5, K_LOAD, 5'd5, 5'd0, 2'b01, 0);
      repeat (38) tick();
      chk("sat_cnt", int'(stall_cnt), 15);
      tick();
      chk("clr_st_stall", int'(stall), 1);
      cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
      chk("clr_st_cnt", int'(stall_cnt), 0);
      tick(); tick();
      chk("post_clr_cnt", int'(stall_cnt), 1);
      tick();
      chk("rst_mid_stall", int'(stall), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      #1;
      chk("rst_mid_sel", int'(fwd_sel), 0);
      chk("rst_mid_cnt", int'(stall_cnt), 0);
      chk("rst_mid_stall_after", int'(stall), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised scoreboard-based forwarding and load-use hazard unit for the VeSPA pipeline. It tracks every in-flight register writer in a DEPTH-entry shift register, from EX to WB. It resolves forwarding selects for NUM_SRC source operands of the instruction in decode and registers them into EX alongside that instruction. It raises a stall when a source depends on a load whose data is not yet available, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- REG_ADDR_W, 5, register-address width
- NUM_SRC, 2, number of source operands checked per instruction
- DEPTH, 3, tracked stages after decode (0=EX, 1=MEM, …, DEPTH-1=WB)
- LOAD_READY, 2, first stage index at which load data can be forwarded
- CNT_W, 16, stall-counter width
- SEL_W, derived = clog2(DEPTH), select width per source
- i_Clk  in  1  clock; all state changes on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_IssueValid  in  1  decode instruction is valid this cycle
- i_IssueWe  in  1  that instruction writes the register file
- i_IssueDst  in  REG_ADDR_W  its destination register
- i_IssueKind  in  2  result source: 2'b10 ALU, 2'b11 LDI, 2'b01 LOAD, 2'b00 none
- i_SrcAddr  in  NUM_SRC*REG_ADDR_W  packed source addresses; source j at [j*REG_ADDR_W +: REG_ADDR_W]
- i_SrcUsed  in  NUM_SRC  source j is actually read
- i_Flush  in  1  squash the instruction in decode and the one in EX
- i_StallCntClr  in  1  clear stall counter
- o_FwdSel  out  NUM_SRC*SEL_W  registered per-source select for EX: 0 = register-file value, k = forward from stage k (1..DEPTH-1)
- o_Stall  out  1  combinational; hold decode and insert a bubble
- o_StallCnt  out  CNT_W  saturating count of stall cycles

## Operation
- Entry e[k] = {valid, dst, kind} describes the instruction in stage k. An entry is a writer if valid && kind != 2'b00.
- Match for source j: the lowest k with e[k] a writer, e[k].dst == src_j, and i_SrcUsed[j]. The youngest producer wins.
- Next-cycle stage of a producer at k is k+1.
- k+1 == DEPTH: the producer writes the RF this cycle. The register file is write-before-read, so the select is 0.
- kind LOAD and k+1 < LOAD_READY: source j is hazarded.
- Otherwise the select for source j is k+1.
- No match: select 0.
- o_Stall = i_IssueValid && !i_Flush && OR(hazards over used sources).
- Shift every cycle, with no hold on older stages: e[k] <= e[k-1] for k ≥ 1.
  - e[0] gets the issue entry if i_IssueValid && i_IssueWe && !o_Stall && !i_Flush.
  - Otherwise e[0] gets a bubble (valid=0).
- i_Flush additionally forces the entry moving into e[1] invalid; the old e[0] is squashed.
- o_FwdSel is loaded with the computed selects when an instruction is accepted (i_IssueValid && !o_Stall && !i_Flush). Otherwise it loads 0.
- Register 0 receives no special treatment and is forwarded like any other register.
- Stall counter:
  - i_StallCntClr → 0. Clear wins over increment.
  - Else o_Stall → +1, saturating at 2^CNT_W−1.
  - Else hold.

## Timing
- Reset: all entries invalid, o_FwdSel=0, o_StallCnt=0. o_Stall=0 in the first cycle after reset.
- Reset asserted mid-operation discards all entries at the next edge. No stall persists.
- Latency: o_Stall is valid in the same cycle as the decode inputs. o_FwdSel is valid in the cycle after acceptance, when the consumer is in EX.
- Load-use with default parameters:
  - Consumer directly after a load: exactly 1 stall cycle, then select 2 (WB).
  - Consumer one instruction later: no stall, select 2.
- A stalled instruction is re-evaluated every cycle; the stall drops as soon as the producer reaches k+1 ≥ LOAD_READY.
- Flush and stall together: flush wins. o_Stall=0, the bubble is inserted, and the counter does not increment.
- Both sources matching the same producer: both selects are identical.

## Test plan
- ALU chaining: issue ALU r3, then add using r3 as src0 → o_Stall=0, next-cycle o_FwdSel[src0]=1. With one unrelated instruction between → 2. With two between → 0.
- Load-use: LOAD r5, then consumer of r5 on src1 → o_Stall=1 for exactly 1 cycle, o_StallCnt=1, then o_FwdSel[src1]=2, and the bubble is visible in e[0].
- Youngest wins: ALU r4, LDI r4, then consumer of r4 → select 1 from the LDI, not 2.
- Flush: LOAD r7 in decode with i_Flush=1, then consumer of r7 → no stall, select 0. Flush during a stall → o_Stall=0, counter unchanged.
- Unused source / no writer: i_SrcUsed=0 or i_IssueKind=00 with a matching address → no stall, select 0.
- Counter: force 2^CNT_W+3 stall cycles (CNT_W=4 build) → saturates at 15. Clear concurrent with a stall → 0. Reset mid-stall → all outputs 0 next cycle.
